uart_tx_sched: RTL
==================

Name: uart_tx_sched

Overview:
Transmit scheduler that shares the single uart_tx serializer between two byte requesters: the core's OUT instruction path (port 0) and the boot-loader/monitor echo path (port 1). It arbitrates requests round-robin into one circular byte buffer. It drives uart_tx through the tx_start/tx_busy handshake, one byte at a time, in FIFO order. It sits beside the write-back stage and replaces ad-hoc buffering there; back-pressure goes to requesters via per-port ready.

Parameters:
ADDR_W, 12, log2 of buffer depth; DEPTH = 2**ADDR_W bytes.
BUSY_WAIT, 4, max cycles after tx_start pulse to wait for tx_busy rise before treating the byte as sent.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  2  per-port byte request; bit 0 = core OUT, bit 1 = loader echo.
req_data0  in  8  byte from port 0.
req_data1  in  8  byte from port 1.
req_ready  out  2  per-port accept; a byte is enqueued on an edge where valid&ready.
tx_data  out  8  byte presented to uart_tx; stable from tx_start cycle until pop.
tx_start  out  1  one-cycle start pulse to uart_tx (registered).
tx_busy  in  1  uart_tx busy flag.
count  out  ADDR_W+1  bytes currently buffered (registered).
idle  out  1  high when buffer empty and FSM in IDLE.

Behaviour:
- Reset (rst high at edge): head=tail=0, count=0, FSM=IDLE, tx_start=0, last_grant=1 (port 0 wins first tie), tx_data=0. Reset mid-transmission abandons the queue. A byte already inside uart_tx finishes on its own; IDLE waits for tx_busy low before the next start.
- full = (count == DEPTH), from registered count only. A same-cycle pop does NOT free space for a push in that cycle.
- Arbitration (combinational): with one valid port, grant it. With both valid, grant the port != last_grant. last_grant updates only on an accepted push.
- req_ready[i] = ~full & grant[i]. At most one push per edge. The ungranted port sees ready=0 and must hold valid/data.
- Push: buf[tail] <= granted data; tail <= tail+1, wrapping modulo DEPTH naturally via ADDR_W bits.
- Pop: head <= head+1 (wrap), on the edge leaving WAIT_DONE (or the BUSY_WAIT timeout).
- count: +1 on push only, -1 on pop only, unchanged on push+pop in the same edge. Never exceeds DEPTH and never underflows.
- FSM, state in registers:
  - IDLE: if count>0 & ~tx_busy -> START.
  - START: tx_start=1, tx_data=buf[head]; -> WAIT_BUSY, timer cleared.
  - WAIT_BUSY: tx_start=0. If tx_busy -> WAIT_DONE. Else if timer==BUSY_WAIT-1 -> pop, IDLE. Else timer++.
  - WAIT_DONE: if ~tx_busy -> pop, IDLE.
- Latency: byte accepted at edge E into an empty idle block (tx_busy low) gives tx_start high in the cycle following edge E+2. Back-to-back bytes are separated by the uart frame plus 2 cycles (IDLE, START).
- idle = (state==IDLE) & (count==0).

Decomposition:
- Package uart_sched_pkg: state enum typedef (IDLE, START, WAIT_BUSY, WAIT_DONE), port index constants PORT_CORE=0 and PORT_LOADER=1, default ADDR_W/BUSY_WAIT localparams.
- Sub-module byte_fifo: circular buffer with head/tail/count, push/pop, full/empty, and a single-port-write/async-read array inferable as distributed or block RAM.
- The top holds the arbiter and FSM.

Test Plan:
- Reset, then port 0 sends 0x41 with tx_busy modeled as high 3 cycles after tx_start for 20 cycles -> exactly one tx_start pulse with tx_data=0x41, count returns 0, idle=1.
- Both ports valid continuously (p0: 0x10,0x11; p1: 0x20,0x21) -> transmit order 0x10,0x20,0x11,0x21; each ready high only on its grant.
- ADDR_W=2, tx_busy stuck high, push 5 bytes from port 0 -> first 4 accepted, count=4, req_ready=0 on the 5th. Release tx_busy -> one pop, 5th accepted next edge (not same edge as pop).
- tx_busy never rises after tx_start (BUSY_WAIT=4) -> byte popped 4 cycles after WAIT_BUSY entry, next byte starts, no deadlock.
- Tail wrap with ADDR_W=2: stream 10 bytes 0x00..0x09 through -> output order preserved across wrap.
- Assert rst while in WAIT_DONE with 3 bytes queued -> next edge count=0, tx_start=0. No new tx_start until tx_busy is low and a new byte is pushed.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_BUSY_WAIT = 4;

endpackage

// File: rtl/uart_tx_sched_byte_fifo.sv
// Circular byte buffer: one write port, asynchronous read of the head entry.
module byte_fifo
    import uart_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [7:0]      push_data,
    input  logic            pop,
    output logic [7:0]      head_data,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH[ADDR_W:0];

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic              do_push;
    logic              do_pop;

    // Full is taken from the registered count, so a pop never makes room for a same-edge push.
    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (do_pop) begin
                head <= head + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding two byte requesters into one uart_tx
// through a shared FIFO and a start/busy handshake FSM.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BUSY_WAIT = DEF_BUSY_WAIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [7:0]      req_data0,
    input  logic [7:0]      req_data1,
    output logic [1:0]      req_ready,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_busy,
    output logic [ADDR_W:0] count,
    output logic            idle
);

    localparam int TIMER_W = $clog2(BUSY_WAIT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_WAIT - 1);

    state_t               state;
    state_t               state_next;
    logic [1:0]           grant;
    logic                 last_grant;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic [7:0]           push_data;
    logic                 pop;
    logic                 load;
    logic [7:0]           head_data;
    logic [TIMER_W-1:0]   timer;

    // On a tie the port that did not win the last accepted push goes next.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT_CORE) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant & {2{~full}};
    assign push      = |(req_valid & req_ready);
    assign push_data = grant[PORT_LOADER] ? req_data1 : req_data0;

    byte_fifo #(
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head_data(head_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!empty && !tx_busy) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // A serializer that never raises busy still releases the byte after BUSY_WAIT cycles.
    always_comb begin
        load = 1'b0;
        pop  = 1'b0;
        case (state)
            START:     load = 1'b1;
            WAIT_BUSY: pop  = !tx_busy && (timer == TIMER_LAST);
            WAIT_DONE: pop  = !tx_busy;
            default: begin
                load = 1'b0;
                pop  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            timer      <= '0;
            last_grant <= PORT_LOADER;
        end else begin
            tx_start <= load;
            if (load) begin
                tx_data <= head_data;
                timer   <= '0;
            end else if (state == WAIT_BUSY && !tx_busy && timer != TIMER_LAST) begin
                timer <= timer + 1'b1;
            end
            if (push) begin
                last_grant <= grant[PORT_LOADER];
            end
        end
    end

    assign idle = (state == IDLE) && empty;

endmodule
